// File: rtl/t03_fetch_responder.sv
// Instruction-fetch responder: one 32-bit bus read per PC request, one-cycle valid pulse on completion.
// Define FETCH_LAST_HIT_EN to add a one-entry last-hit buffer that answers repeat fetches without the bus.
module t03_fetch_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] RESET_INSTR    = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        i_request,
    input  logic [31:0] i_addr,
    input  logic        flush,
    input  logic        inval,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        fetch_err,
    output logic        bus_read,
    output logic [31:0] bus_addr,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_q, instr_d;
    logic          err_q, err_d;
    logic [31:0]   addr_q, addr_d;

    logic          hit;
    logic [31:0]   hit_data;

`ifdef FETCH_LAST_HIT_EN
    logic [31:0] last_addr_q;
    logic [31:0] last_data_q;
    logic        last_ok_q;
    logic        fill;

    assign hit      = last_ok_q && (i_addr == last_addr_q);
    assign hit_data = last_data_q;
    // Only a completed, unflushed bus read is trusted as a buffer entry.
    assign fill     = (state_q == S_WAIT) && !flush && bus_ack;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            last_addr_q <= '0;
            last_data_q <= '0;
            last_ok_q   <= 1'b0;
        end else if (inval) begin
            last_ok_q   <= 1'b0;
        end else if (fill) begin
            last_addr_q <= addr_q;
            last_data_q <= bus_rdata;
            last_ok_q   <= 1'b1;
        end
    end
`else
    logic unused_inval;

    assign hit          = 1'b0;
    assign hit_data     = RESET_INSTR;
    assign unused_inval = inval;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        instr_d = instr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (i_request && !flush) begin
                    if (i_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        instr_d = RESET_INSTR;
                        state_d = S_DONE;
                    end else if (hit) begin
                        instr_d = hit_data;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = {i_addr[31:2], 2'b00};
                        count_d = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A flush beats a same-cycle ack; the bus may still answer, so drain it.
                if (flush) begin
                    count_d = '0;
                    state_d = S_DRAIN;
                end else if (bus_ack) begin
                    instr_d = bus_rdata;
                    state_d = S_DONE;
                end else if (count_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    instr_d = RESET_INSTR;
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                if (bus_ack || (count_q == CNT_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            instr_q <= RESET_INSTR;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = (state_q == S_DONE) && !flush;
    assign fetch_busy  = (state_q != S_IDLE);
    assign fetch_err   = err_q;
    assign bus_read    = (state_q == S_WAIT);
    assign bus_addr    = addr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_t03_fetch_responder.sv
// Self-checking bench for t03_fetch_responder: scenario tasks plus a scoreboard on instr_valid pulses.
// Covers FETCH_LAST_HIT_EN both when defined and when not.
module tb_t03_fetch_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        nrst  = 1'b1;
    logic        i_request = 1'b0;
    logic [31:0] i_addr = '0;
    logic        flush = 1'b0;
    logic        inval = 1'b0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fetch_err;
    logic        bus_read;
    logic [31:0] bus_addr;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [1:0]  dbg_state;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          valid_cnt = 0;
    int          cyc       = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    t03_fetch_responder dut (
        .clock       (clock),
        .nrst        (nrst),
        .i_request   (i_request),
        .i_addr      (i_addr),
        .flush       (flush),
        .inval       (inval),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .fetch_busy  (fetch_busy),
        .fetch_err   (fetch_err),
        .bus_read    (bus_read),
        .bus_addr    (bus_addr),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack),
        .dbg_state_o (dbg_state)
    );

    // Clock / cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Scoreboard: every valid pulse must match the oldest expected word
    always @(negedge clock) begin
        if (nrst && instr_valid) begin
            valid_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_valid: instr_out=%h with no fetch outstanding", instr_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (instr_out !== mon_exp) $display("FAIL sb_instr_out: got %h, required %h", instr_out, mon_exp);
                else n_pass++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    // Driver tasks (all start and end at a negedge with the DUT idle)
    task automatic start_reset();
        nrst = 1'b0; i_request = 1'b0; i_addr = '0; flush = 1'b0; inval = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0;
        @(negedge clock);
        @(negedge clock);
        nrst = 1'b1;
        @(negedge clock);
    endtask

    task automatic bus_fetch(input logic [31:0] a, input logic [31:0] d, input int delay,
                             output int lat, output logic rd_seen, output logic [31:0] addr_seen);
        i_request = 1'b1; i_addr = a; exp_q.push_back(d);
        @(posedge clock); #1;
        i_request = 1'b0; i_addr = $urandom;
        @(negedge clock);
        rd_seen = bus_read; addr_seen = bus_addr; lat = 0;
        repeat (delay) begin @(negedge clock); lat++; end
        bus_ack = 1'b1; bus_rdata = d;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            bus_ack = 1'b0; bus_rdata = $urandom; lat++;
            if (instr_valid) break;
        end
        @(negedge clock);
    endtask

    task automatic req_only(input logic [31:0] a, input logic [31:0] e, output int lat, output int rd_cnt);
        i_request = 1'b1; i_addr = a; exp_q.push_back(e);
        @(posedge clock); #1;
        i_request = 1'b0; i_addr = $urandom;
        lat = 0; rd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (instr_valid) break;
            if (bus_read) rd_cnt++;
            lat++;
        end
        @(negedge clock);
    endtask

    // Scenarios
    task automatic test_reset();
        int bad;
        #2 nrst = 1'b0;
        #2;
        n_checks++; if (instr_out !== NOP) $display("FAIL rst_instr_out: got %h, required %h", instr_out, NOP); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", instr_valid); else n_pass++;
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", fetch_busy); else n_pass++;
        n_checks++; if (fetch_err !== 1'b0) $display("FAIL rst_err: got %b, required 0", fetch_err); else n_pass++;
        n_checks++; if (bus_read !== 1'b0) $display("FAIL rst_bus_read: got %b, required 0", bus_read); else n_pass++;
        n_checks++; if (bus_addr !== 32'h0) $display("FAIL rst_bus_addr: got %h, required 0", bus_addr); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL rst_state: got %0d, required 0", dbg_state); else n_pass++;
        @(negedge clock);
        nrst = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus_read || fetch_busy || instr_valid) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL rst_idle_activity: got %0d active cycles, required 0", bad); else n_pass++;
    endtask

    task automatic test_fetch();
        int lat; logic rd; logic [31:0] a; int v0;
        start_reset();
        v0 = valid_cnt;
        bus_fetch(32'h0000_0100, 32'h0050_0093, 2, lat, rd, a);
        n_checks++; if (rd !== 1'b1) $display("FAIL fetch_bus_read: got %b, required 1", rd); else n_pass++;
        n_checks++; if (a !== 32'h100) $display("FAIL fetch_bus_addr: got %h, required 00000100", a); else n_pass++;
        n_checks++; if (lat !== 3) $display("FAIL fetch_latency: got %0d, required 3", lat); else n_pass++;
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL fetch_busy_after: got %b, required 0", fetch_busy); else n_pass++;
        repeat (3) @(negedge clock);
        n_checks++; if (valid_cnt - v0 !== 1) $display("FAIL fetch_pulse_count: got %0d, required 1", valid_cnt - v0); else n_pass++;
        bus_fetch(32'h0000_0104, 32'h00A0_0113, 0, lat, rd, a);
        n_checks++; if (lat !== 1) $display("FAIL fetch_min_latency: got %0d, required 1", lat); else n_pass++;
    endtask

    task automatic test_timeout();
        int lat, rd_cnt; logic rd; logic [31:0] a;
        start_reset();
        bus_fetch(32'h0000_0180, 32'h1234_5678, 0, lat, rd, a);
        n_checks++; if (fetch_err !== 1'b0) $display("FAIL to_err_before: got %b, required 0", fetch_err); else n_pass++;
        req_only(32'h0000_0200, NOP, lat, rd_cnt);
        n_checks++; if (rd_cnt !== 16) $display("FAIL to_bus_read_cycles: got %0d, required 16", rd_cnt); else n_pass++;
        n_checks++; if (lat !== 16) $display("FAIL to_latency: got %0d, required 16", lat); else n_pass++;
        n_checks++; if (fetch_err !== 1'b1) $display("FAIL to_err: got %b, required 1", fetch_err); else n_pass++;
        n_checks++; if (instr_out !== NOP) $display("FAIL to_instr_out: got %h, required %h", instr_out, NOP); else n_pass++;
        repeat (3) @(negedge clock);
        n_checks++; if (fetch_err !== 1'b1) $display("FAIL to_err_sticky: got %b, required 1", fetch_err); else n_pass++;
    endtask

    task automatic test_misaligned();
        int lat, rd_cnt; logic rd; logic [31:0] a;
        start_reset();
        req_only(32'h0000_0102, NOP, lat, rd_cnt);
        n_checks++; if (rd_cnt !== 0) $display("FAIL mis_bus_read: got %0d cycles, required 0", rd_cnt); else n_pass++;
        n_checks++; if (lat !== 0) $display("FAIL mis_latency: got %0d, required 0", lat); else n_pass++;
        n_checks++; if (fetch_err !== 1'b1) $display("FAIL mis_err: got %b, required 1", fetch_err); else n_pass++;
        bus_fetch(32'h0000_0108, 32'hCAFE_0013, 1, lat, rd, a);
        n_checks++; if (lat !== 2) $display("FAIL mis_next_latency: got %0d, required 2", lat); else n_pass++;
        n_checks++; if (fetch_err !== 1'b1) $display("FAIL mis_err_sticky: got %b, required 1", fetch_err); else n_pass++;
    endtask

    task automatic test_flush();
        int lat, bad, v0; logic rd; logic [31:0] a;
        start_reset();
        bus_fetch(32'h0000_0100, 32'h0AAA_0093, 0, lat, rd, a);
        v0 = valid_cnt;
        // flush in IDLE masks a pending request
        i_request = 1'b1; i_addr = 32'h400; flush = 1'b1; bad = 0;
        repeat (3) begin @(negedge clock); if (bus_read || fetch_busy) bad++; end
        i_request = 1'b0; flush = 1'b0;
        n_checks++; if (bad !== 0) $display("FAIL fl_idle_ignored: got %0d busy cycles, required 0", bad); else n_pass++;
        // flush in WAIT, stray ack drained
        i_request = 1'b1; i_addr = 32'h300;
        @(posedge clock); #1 i_request = 1'b0;
        @(negedge clock);
        n_checks++; if (bus_read !== 1'b1) $display("FAIL fl_wait_read: got %b, required 1", bus_read); else n_pass++;
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        n_checks++; if (bus_read !== 1'b0) $display("FAIL fl_drain_read: got %b, required 0", bus_read); else n_pass++;
        n_checks++; if (dbg_state !== 2'd3) $display("FAIL fl_drain_state: got %0d, required 3", dbg_state); else n_pass++;
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        bus_ack = 1'b0;
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL fl_back_idle: got %b, required 0", fetch_busy); else n_pass++;
        n_checks++; if (instr_out !== 32'h0AAA_0093) $display("FAIL fl_instr_kept: got %h, required 0aaa0093", instr_out); else n_pass++;
        n_checks++; if (fetch_err !== 1'b0) $display("FAIL fl_no_err: got %b, required 0", fetch_err); else n_pass++;
        // flush in DONE suppresses the pulse but keeps the data
        i_request = 1'b1; i_addr = 32'h500;
        @(posedge clock); #1 i_request = 1'b0;
        @(negedge clock);
        bus_ack = 1'b1; bus_rdata = 32'h0BBB_0113;
        @(posedge clock); #1 bus_ack = 1'b0; flush = 1'b1;
        @(negedge clock);
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL fl_done_valid: got %b, required 0", instr_valid); else n_pass++;
        n_checks++; if (instr_out !== 32'h0BBB_0113) $display("FAIL fl_done_instr: got %h, required 0bbb0113", instr_out); else n_pass++;
        @(posedge clock); #1 flush = 1'b0;
        @(negedge clock);
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL fl_done_idle: got %b, required 0", fetch_busy); else n_pass++;
        n_checks++; if (valid_cnt - v0 !== 0) $display("FAIL fl_no_pulse: got %0d pulses, required 0", valid_cnt - v0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, c0, dly; logic rd; logic [31:0] a, addr, data;
        start_reset();
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            addr = 32'h2000 + (k << 4) + (32'($urandom_range(0, 3)) << 2);
            bus_fetch(addr, $urandom, 0, lat, rd, a);
            n_checks++; if (lat !== 1) $display("FAIL b2b_latency[%0d]: got %0d, required 1", k, lat); else n_pass++;
        end
        n_checks++; if (cyc - c0 !== 9) $display("FAIL b2b_cycles: got %0d, required 9", cyc - c0); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            addr = 32'h3000 + (k << 4) + (32'($urandom_range(0, 3)) << 2);
            data = $urandom;
            dly  = $urandom_range(0, 6);
            bus_fetch(addr, data, dly, lat, rd, a);
            n_checks++; if (lat !== dly + 1) $display("FAIL rnd_latency[%0d]: got %0d, required %0d", k, lat, dly + 1); else n_pass++;
            n_checks++; if (a !== addr) $display("FAIL rnd_bus_addr[%0d]: got %h, required %h", k, a, addr); else n_pass++;
        end
    endtask

    task automatic test_last_hit();
        int lat, rd_cnt; logic rd; logic [31:0] a;
        start_reset();
        bus_fetch(32'h0000_0100, 32'h0010_0093, 0, lat, rd, a);
        n_checks++; if (rd !== 1'b1) $display("FAIL lh_first_bus: got %b, required 1", rd); else n_pass++;
`ifdef FETCH_LAST_HIT_EN
        req_only(32'h0000_0100, 32'h0010_0093, lat, rd_cnt);
        n_checks++; if (lat !== 0) $display("FAIL lh_hit_latency: got %0d, required 0", lat); else n_pass++;
        n_checks++; if (rd_cnt !== 0) $display("FAIL lh_hit_no_bus: got %0d, required 0", rd_cnt); else n_pass++;
        flush = 1'b1; @(negedge clock); flush = 1'b0;
        req_only(32'h0000_0100, 32'h0010_0093, lat, rd_cnt);
        n_checks++; if (lat !== 0) $display("FAIL lh_hit_after_flush: got %0d, required 0", lat); else n_pass++;
        inval = 1'b1; @(negedge clock); inval = 1'b0;
        bus_fetch(32'h0000_0100, 32'h0020_0093, 1, lat, rd, a);
        n_checks++; if (rd !== 1'b1) $display("FAIL lh_inval_bus: got %b, required 1", rd); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL lh_inval_latency: got %0d, required 2", lat); else n_pass++;
`else
        bus_fetch(32'h0000_0100, 32'h0020_0093, 0, lat, rd, a);
        n_checks++; if (rd !== 1'b1) $display("FAIL lh_repeat_bus: got %b, required 1", rd); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL lh_repeat_latency: got %0d, required 1", lat); else n_pass++;
        inval = 1'b1; @(negedge clock); inval = 1'b0;
        req_only(32'h0000_0100, NOP, lat, rd_cnt);
        n_checks++; if (rd_cnt !== 16) $display("FAIL lh_inval_ignored: got %0d, required 16", rd_cnt); else n_pass++;
`endif
    endtask

    task automatic test_reset_midfetch();
        i_request = 1'b1; i_addr = 32'h600;
        @(posedge clock); #1 i_request = 1'b0;
        #2;
        n_checks++; if (bus_read !== 1'b1) $display("FAIL mid_read_before: got %b, required 1", bus_read); else n_pass++;
        nrst = 1'b0;
        #1;
        n_checks++; if (bus_read !== 1'b0) $display("FAIL mid_read_async: got %b, required 0", bus_read); else n_pass++;
        n_checks++; if (fetch_busy !== 1'b0) $display("FAIL mid_busy: got %b, required 0", fetch_busy); else n_pass++;
        n_checks++; if (instr_out !== NOP) $display("FAIL mid_instr_out: got %h, required %h", instr_out, NOP); else n_pass++;
        n_checks++; if (bus_addr !== 32'h0) $display("FAIL mid_bus_addr: got %h, required 0", bus_addr); else n_pass++;
        @(negedge clock);
        nrst = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_timeout();
        test_misaligned();
        test_flush();
        test_back_to_back();
        test_last_hit();
        test_reset_midfetch();
        repeat (3) @(negedge clock);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
